// File: rtl/ysyx_22050039_imem_resp.sv
// Instruction memory responder: a word-addressed instruction store with a
// program-load write port and a single-outstanding fetch handshake. The
// fetched word (or an access fault) is captured on the accept edge and
// presented LATENCY cycles later until the requester takes it.
module ysyx_22050039_imem_resp #(
  parameter int                XLEN     = 64,
  parameter int                INST_LEN = 32,
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 2,
  parameter logic [XLEN-1:0]   BASE     = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [XLEN-1:0]     req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [INST_LEN-1:0] resp_inst,
  output logic                resp_err,
  input  logic                wr_en,
  input  logic [XLEN-1:0]     wr_addr,
  input  logic [INST_LEN-1:0] wr_data
);

  localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int              LOAD  = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [XLEN-1:0] SPAN  = XLEN'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [INST_LEN-1:0] mem [DEPTH];

  // Offsets are unsigned XLEN-bit; the lower-bound compare stops addresses
  // below BASE from wrapping around into the window.
  logic [XLEN-1:0]    rd_off, wr_off;
  logic               rd_ok, wr_ok;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               accept;

  assign rd_off = req_addr - BASE;
  assign wr_off = wr_addr - BASE;
  assign rd_ok  = (req_addr[1:0] == 2'b00) && (req_addr >= BASE) && (rd_off < SPAN);
  assign wr_ok  = (wr_addr[1:0] == 2'b00) && (wr_addr >= BASE) && (wr_off < SPAN);
  assign rd_idx = IDX_W'(rd_off >> 2);
  assign wr_idx = IDX_W'(wr_off >> 2);

  // req_ready is qualified by rst so it drops the instant reset asserts
  // and rises together with its release.
  assign req_ready  = (state_q == IDLE) && rst;
  assign resp_valid = (state_q == RESP);
  assign accept     = req_ready && req_valid;

  // Program-load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept -> WAIT (or RESP with no latency) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response register: the word is read on the accept edge, so a write to
  // the same word on that edge is not seen, and nothing later disturbs it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_inst <= '0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      resp_err  <= !rd_ok;
      resp_inst <= rd_ok ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_imem_resp.sv
// Bench for ysyx_22050039_imem_resp: directed scenarios followed by randomized
// fetches, checked against a word-array model of the memory and fault rules.
module tb_ysyx_22050039_imem_resp;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] TOP   = BASE + 64'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, resp_ready = 1'b0, wr_en = 1'b0;
  logic [63:0] req_addr = '0, wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst;

  logic        z_req_valid = 1'b0, z_resp_ready = 1'b0, z_wr_en = 1'b0;
  logic [63:0] z_req_addr = '0, z_wr_addr = '0;
  logic [31:0] z_wr_data = '0;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_inst;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  ysyx_22050039_imem_resp #(.XLEN(XLEN), .INST_LEN(32), .DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  ysyx_22050039_imem_resp #(.XLEN(XLEN), .INST_LEN(32), .DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_inst(z_resp_inst), .resp_err(z_resp_err),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [63:0] a);
    return (a % 4 == 0) && (a >= BASE) && (a < TOP);
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [31:0] d);
    if (addr_ok(a)) mdl[int'((a - BASE) / 4)] = d;
  endtask

  task automatic model_read(input logic [63:0] a, output logic ee, output logic [31:0] ei);
    ee = !addr_ok(a);
    ei = ee ? 32'h0 : mdl[int'((a - BASE) / 4)];
  endtask

  // Single program-load write on the LATENCY=2 instance; called at a negedge.
  task automatic wr(input logic [63:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_write(a, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One full fetch transaction, starting and ending at a negedge.
  task automatic do_req(input logic [63:0] addr, input int hold, input bit cw,
                        input logic [31:0] cwd, input bit noise);
    logic        ee;
    logic [31:0] ei;
    logic [31:0] d;
    bit          w;
    int          n;
    model_read(addr, ee, ei);
    req_valid = 1'b1; req_addr = addr;
    if (cw) begin wr_en = 1'b1; wr_addr = addr; wr_data = cwd; end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    if (cw) model_write(addr, cwd);
    @(negedge clk);
    wr_en = 1'b0;
    if (noise) begin req_addr = {$urandom, $urandom}; resp_ready = 1'b1; end
    else begin req_valid = 1'b0; resp_ready = 1'b0; end
    check("inst_at_accept", 64'(resp_inst), 64'(ei));
    check("err_at_accept", 64'(resp_err), 64'(ee));
    n = 0;
    while (resp_valid !== 1'b1 && n < 16) begin
      check("req_ready_busy", 64'(req_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
    check("resp_inst", 64'(resp_inst), 64'(ei));
    check("resp_err", 64'(resp_err), 64'(ee));
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      w = noise;
      d = $urandom;
      if (w) begin wr_en = 1'b1; wr_addr = addr; wr_data = d; end
      @(posedge clk);
      if (w) model_write(addr, d);
      @(negedge clk);
      wr_en = 1'b0;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_inst", 64'(resp_inst), 64'(ei));
      check("hold_err", 64'(resp_err), 64'(ee));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b0;
    check("done_valid", 64'(resp_valid), 64'd0);
    check("done_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] d;
    int          sel;
    foreach (mdl[i]) mdl[i] = 32'h0;

    // Reset values while asserted.
    #3 rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_inst", 64'(resp_inst), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_req_ready", 64'(req_ready), 64'd1);

    // Preload a small window plus the last word, then dropped writes.
    for (int i = 0; i < 16; i++) wr(BASE + 64'(4 * i), $urandom);
    wr(BASE, 32'h0000_0413);
    wr(BASE + 64'h10, 32'h0010_0073);
    wr(TOP - 4, $urandom);
    wr(BASE + 64'h11, 32'h1111_1111);
    wr(TOP, 32'h2222_2222);
    wr(BASE - 4, 32'h3333_3333);

    // Basic fetch, faults, long hold, write on accept edge.
    do_req(BASE, 0, 1'b0, 32'h0, 1'b0);
    do_req(BASE + 64'h2, 0, 1'b0, 32'h0, 1'b0);
    do_req(BASE - 64'h4, 0, 1'b0, 32'h0, 1'b0);
    do_req(TOP, 0, 1'b0, 32'h0, 1'b0);
    do_req(TOP - 4, 0, 1'b0, 32'h0, 1'b0);
    do_req(BASE + 64'h8, 5, 1'b0, 32'h0, 1'b0);
    do_req(BASE + 64'h10, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_req(BASE + 64'h10, 0, 1'b0, 32'h0, 1'b0);
    check("word10_new", 64'(mdl[4]), 64'h0000_0000_DEAD_BEEF);

    // Reset during WAIT discards the request and keeps memory.
    req_valid = 1'b1; req_addr = BASE + 64'h4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("wrst_req_ready", 64'(req_ready), 64'd0);
    check("wrst_resp_valid", 64'(resp_valid), 64'd0);
    check("wrst_resp_inst", 64'(resp_inst), 64'd0);
    check("wrst_resp_err", 64'(resp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wrst_release_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("wrst_no_resp", 64'(resp_valid), 64'd0);
    end
    do_req(BASE, 0, 1'b0, 32'h0, 1'b0);

    // Randomized fetches.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1:    a = BASE + 64'(4 * $urandom_range(0, 15));
        2:       a = TOP - 4;
        3:       a = BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
        4:       a = BASE - 64'(4 * $urandom_range(1, 4));
        5:       a = TOP + 64'(4 * $urandom_range(0, 3));
        default: a = {$urandom, $urandom};
      endcase
      do_req(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Zero-latency instance: response visible right after the accept edge.
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      a = (k == 2) ? BASE + 64'h6 : BASE + 64'(4 * k);
      z_wr_en = 1'b1; z_wr_addr = BASE + 64'(4 * k); z_wr_data = d;
      @(posedge clk);
      @(negedge clk);
      z_wr_en = 1'b0;
      z_req_valid = 1'b1; z_req_addr = a;
      check("z_req_ready", 64'(z_req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      z_req_valid = 1'b0;
      check("z_resp_valid", 64'(z_resp_valid), 64'd1);
      check("z_resp_inst", 64'(z_resp_inst), (k == 2) ? 64'd0 : 64'(d));
      check("z_resp_err", 64'(z_resp_err), (k == 2) ? 64'd1 : 64'd0);
      z_resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      z_resp_ready = 1'b0;
      check("z_done_valid", 64'(z_resp_valid), 64'd0);
      check("z_done_ready", 64'(z_req_ready), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
